// File: rtl/ysyx_22041412_wbu.sv
// Writeback unit: arbitrates EXU/LSU results onto the register file write port and emits a commit pulse.
// Optional performance counters are enabled with `define YSYX_22041412_WBU_PERF_EN.
module ysyx_22041412_wbu #(
    parameter int XLEN       = 64,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic [XLEN-1:0] exu_pc,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [XLEN-1:0] lsu_pc,
    output logic            Wen,
    output logic [4:0]      Rw,
    output logic [XLEN-1:0] BusW,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc
`ifdef YSYX_22041412_WBU_PERF_EN
    ,
    output logic [63:0]     perf_wb_cnt,
    output logic [63:0]     perf_exu_stall
`endif
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [3:0]      starve_cnt;
    logic            starve;
    logic            accept_p0;
    logic [4:0]      rd_p0;
    logic [XLEN-1:0] data_p0;
    logic [XLEN-1:0] pc_p0;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= LIM) ? LIM : cnt + 4'd1;
    endfunction

    // Stage p0: combinational grant; LSU normally wins unless EXU has lost STARVE_LIM times in a row.
    always_comb begin
        starve    = exu_valid && (starve_cnt == LIM);
        lsu_ready = lsu_valid && !starve;
        exu_ready = exu_valid && !lsu_ready;
        accept_p0 = lsu_ready || exu_ready;
        rd_p0     = lsu_ready ? lsu_rd   : exu_rd;
        data_p0   = lsu_ready ? lsu_data : exu_data;
        pc_p0     = lsu_ready ? lsu_pc   : exu_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (!exu_valid || exu_ready) begin
            starve_cnt <= 4'd0;
        end else if (lsu_ready) begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // Stage p1: registered writeback / commit; pulses last exactly one cycle per accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Wen          <= 1'b0;
            Rw           <= 5'd0;
            BusW         <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else if (accept_p0) begin
            Wen          <= (rd_p0 != 5'd0);
            Rw           <= rd_p0;
            BusW         <= data_p0;
            commit_valid <= 1'b1;
            commit_pc    <= pc_p0;
        end else begin
            Wen          <= 1'b0;
            commit_valid <= 1'b0;
        end
    end

`ifdef YSYX_22041412_WBU_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_wb_cnt    <= 64'd0;
            perf_exu_stall <= 64'd0;
        end else begin
            if (commit_valid) perf_wb_cnt <= perf_wb_cnt + 64'd1;
            if (exu_valid && !exu_ready) perf_exu_stall <= perf_exu_stall + 64'd1;
        end
    end
`endif

endmodule
